// File: rtl/addsub_digit_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, NDIG = WIDTH/DIGIT cycles per op.
// Define ADDSUB_SATURATE_EN to clamp the result on signed overflow instead of wrapping.
module addsub_digit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT:0]   slice_sum;
    logic             cout;
    logic             cin_msb;
    logic             ovf;
    logic             last;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] s_fin;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("addsub_digit_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

`ifdef ADDSUB_SATURATE_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic ovf_i,
                                                  input logic neg);
        logic signed [WIDTH-1:0] smax;
        logic signed [WIDTH-1:0] smin;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if (!ovf_i)
            return raw;
        return neg ? smin : smax;
    endfunction
`endif

    // Operands shift right each RUN cycle, so the active slice is always the low DIGIT bits
    // and finished result digits enter at the top of res.
    always_comb begin
        slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
        cout      = slice_sum[DIGIT];
        cin_msb   = slice_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        ovf       = cin_msb ^ cout;
        last      = (cnt == LAST_DIG);
        res_next  = (res >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef ADDSUB_SATURATE_EN
        // On overflow both effective operands share the sign of a, which picks the clamp direction.
        s_fin     = saturate(res_next, ovf, a_sh[DIGIT-1]);
`else
        s_fin     = res_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            cnt       <= '0;
            cy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cy       <= sel;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    cy  <= cout;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        s         <= s_fin;
                        carry     <= cout;
                        overflow  <= ovf;
                        zero      <= (s_fin == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Operand/accumulator path carries no reset: every op overwrites all of it before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_sh <= a;
            b_sh <= sel ? ~b : b;
        end else if (state == RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
            res  <= res_next;
        end
    end
endmodule

// File: tb/tb_addsub_digit_serial.sv
// Self-checking bench for addsub_digit_serial: directed corner cases, handshake/reset, random ops.
module tb_addsub_digit_serial;
    localparam int W    = 32;
    localparam int D    = 8;
    localparam int NDIG = W / D;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sel = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         carry;
    logic         overflow;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    addsub_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole word.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msel,
                                  output logic [W-1:0] ms, output logic mc, output logic mv,
                                  output logic mz);
        longint sa, sb, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        r  = msel ? sa - sb : sa + sb;
        mv = (r > SMAX) || (r < SMIN);
        ms = msel ? ma - mb : ma + mb;
        mc = msel ? (ma >= mb) : ((longint'(ma) + longint'(mb)) >= (longint'(1) << W));
`ifdef ADDSUB_SATURATE_EN
        if (r > SMAX) ms = W'(SMAX);
        if (r < SMIN) ms = W'(SMIN);
`endif
        mz = (ms == '0);
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", in_ready, 1);
        a = ta; b = tbv; sel = ts; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the bus during RUN; it must be ignored.
        a = $urandom; b = $urandom; sel = 1'($urandom_range(0, 1));
        chk("accept_in_ready", in_ready, 0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, NDIG);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_out_valid", out_valid, 0);
        chk("consume_in_ready", in_ready, 1);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] es, input logic ec,
                             input logic ev, input logic ez);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_carry"}, carry, ec);
        chk({tag, "_ovf"}, overflow, ev);
        chk({tag, "_zero"}, zero, ez);
    endtask

    task automatic do_dir(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input logic ev, input logic ez);
        int lat;
        send(ta, tbv, ts);
        wait_result(lat);
        check_out(tag, es, ec, ev, ez);
        consume();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] es, ta, tbv;
        logic ec, ev, ez, ts;

        repeat (3) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {carry, overflow, zero}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        do_dir("add", 32'h00D70B8B, 32'h00000B8B, 1'b0, 32'h00D71716, 1'b0, 1'b0, 1'b0);
        do_dir("sub", 32'h00D70B8B, 32'h00000B8B, 1'b1, 32'h00D70000, 1'b1, 1'b0, 1'b0);
        do_dir("sub_zero", 32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        do_dir("borrow", 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        do_dir("pos_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        do_dir("neg_ovf", 32'h80000000, 32'd1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
`else
        do_dir("pos_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        do_dir("neg_ovf", 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
`endif

        // Backpressure: result held for 10 cycles while a new op waits on the bus.
        send(32'h12345678, 32'h0F0F0F0F, 1'b0);
        wait_result(lat);
        model(32'h12345678, 32'h0F0F0F0F, 1'b0, es, ec, ev, ez);
        a = 32'd3; b = 32'd4; sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_out("hold", es, ec, ev, ez);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_accept", in_ready, 0);
        wait_result(lat);
        check_out("after_hold", 32'd7, 1'b0, 1'b0, 1'b0);
        consume();

        // Reset two digits into RUN: op discarded, outputs cleared.
        send(32'hCAFEBABE, 32'h01234567, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_s", s, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_flags", {carry, overflow, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        repeat (NDIG + 2) @(negedge clk);
        chk("postrst_no_result", out_valid, 0);
        chk("postrst_s", s, 0);
        do_dir("post_rst_add", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Random operations mixed with corner operand values.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: ta = 32'h7FFFFFFF;
                1: ta = 32'h80000000;
                2: ta = 32'h0;
                default: ta = $urandom;
            endcase
            tbv = ($urandom_range(0, 3) == 0) ? ta : $urandom;
            ts  = 1'($urandom_range(0, 1));
            model(ta, tbv, ts, es, ec, ev, ez);
            send(ta, tbv, ts);
            wait_result(lat);
            check_out("rand", es, ec, ev, ez);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rand_hold_s", s, es);
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addsub_digit_serial.md
Name: addsub_digit_serial

Overview:
- Parametrised, sequential successor to the team's 32x32 combinational adder/subtractor.
- Computes A+B or A-B over a configurable word width, DIGIT bits per clock, trading latency for area.
- Valid/ready handshakes on input and output; sits between the sensor/accumulator datapath and the controller.
- Returns carry, signed-overflow and zero flags with the result.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 2.
- DIGIT, 8: bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and sel are valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- s  out  WIDTH  result
- carry  out  1  carry-out of MSB. For subtract: 1 = no borrow.
- overflow  out  1  signed (two's complement) overflow
- zero  out  1  s == 0

Behaviour:
- Single clock, asynchronous active-low reset. All state and outputs are registered.
- Reset (rst_n=0, at any time, including mid-RUN or DONE):
  - state = IDLE; s, carry, overflow, zero, out_valid all 0; digit counter 0.
  - Any in-flight operation is discarded, with no partial result.
- in_ready = (state==IDLE). It is 1 whenever rst_n=1 and the block is idle.
- FSM:
  - IDLE: on an edge with in_valid && in_ready:
    - latch a, and b (or ~b when sel=1); latch sel.
    - carry register = sel (so subtract is A + ~B + 1).
    - counter = 0; go to RUN.
  - RUN: each edge adds one DIGIT-wide slice, LSB slice first:
    - slice = a_slice + b_slice + carry.
    - low DIGIT bits go into the result register at slice position counter; carry register = slice carry-out.
    - counter increments.
    - On the edge processing slice NDIG-1: compute the flags, go to DONE, out_valid=1.
  - DONE: s and flags held stable while out_valid=1. On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready=0 throughout DONE.
- Latency: out_valid rises exactly NDIG clock edges after the acceptance edge.
  - Maximum throughput: one operation per NDIG+2 cycles (out_ready held high, in_valid held high).
- Flags, computed on the final digit:
  - carry = final carry-out.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (final s == 0).
- Width rules:
  - Result wraps modulo 2^WIDTH (unless the optional feature is compiled in).
  - The input bus is ignored outside IDLE. Changing a, b or sel during RUN has no effect.
- out_ready while out_valid=0 is ignored. in_valid while not in IDLE is ignored, and the op is not accepted.
- DIGIT == WIDTH is legal: NDIG=1, single RUN cycle.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - On signed overflow, s is clamped: positive overflow gives 0 followed by WIDTH-1 ones; negative overflow gives 1 followed by WIDTH-1 zeros.
  - The overflow flag is still reported as 1; carry reports the raw carry-out.
  - zero is evaluated on the clamped value.
  - Clamping is applied on the final RUN edge, so latency is unchanged.
- Not defined: s wraps modulo 2^WIDTH; no clamping logic is present.

Test Plan:
- WIDTH=32, DIGIT=8; a=0x00D70B8B (14093195), b=0x00000B8B (2955), sel=0, out_ready=1:
  - out_valid rises 4 edges after acceptance.
  - s=0x00D71716 (14096150), carry=0, overflow=0, zero=0.
- Same operands, sel=1 → s=0x00D70000 (14090240), carry=1, overflow=0, zero=0.
- a=5, b=5, sel=1 → s=0, zero=1, carry=1.
- a=0, b=1, sel=1 → s=0xFFFFFFFF, carry=0 (borrow), overflow=0.
- a=0x7FFFFFFF, b=1, sel=0 → overflow=1, carry=0.
  - Without the macro: s=0x80000000.
  - With ADDSUB_SATURATE_EN: s=0x7FFFFFFF, zero=0.
- Handshake, backpressure and reset:
  - Hold out_ready=0 for 10 cycles after out_valid: s, flags and out_valid stay stable and in_ready stays 0.
  - Raise out_ready: IDLE the next cycle, and a new op is accepted 1 cycle later.
  - Assert rst_n=0 for one cycle midway through RUN (after 2 digits):
    - all outputs read 0 and in_ready=1 after release;
    - a subsequent op (a=3, b=4, sel=0) gives s=7.
